// File: rtl/ps2_tx_arbiter_if.sv
// rtl/ps2_tx_arbiter_if.sv - byte-stream inputs, FIFO status and PS/2 bus outputs of ps2_tx_arbiter
interface ps2_tx_arbiter_if;
    logic [7:0] kbd_data;
    logic       kbd_wr;
    logic [7:0] mouse_data;
    logic       mouse_wr;
    logic       kbd_full;
    logic       mouse_full;
    logic       kbd_ovf;
    logic       mouse_ovf;
    logic       busy;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       ps2_mouse_clk;
    logic       ps2_mouse_data;

    modport master (
        output kbd_data, kbd_wr, mouse_data, mouse_wr,
        input  kbd_full, mouse_full, kbd_ovf, mouse_ovf, busy,
        input  ps2_kbd_clk, ps2_kbd_data, ps2_mouse_clk, ps2_mouse_data
    );

    modport slave (
        input  kbd_data, kbd_wr, mouse_data, mouse_wr,
        output kbd_full, mouse_full, kbd_ovf, mouse_ovf, busy,
        output ps2_kbd_clk, ps2_kbd_data, ps2_mouse_clk, ps2_mouse_data
    );
endinterface

// File: rtl/ps2_tx_arbiter.sv
// rtl/ps2_tx_arbiter.sv - keyboard/mouse FIFOs sharing one PS/2 device-side serializer, round-robin per byte
// Define PS2_MOUSE_PKT_LOCK_EN to keep each 3-byte mouse packet contiguous.
module ps2_tx_arbiter #(
    parameter int FIFO_BITS = 3,
    parameter int CLK_DIV   = 16
) (
    input logic             clk,
    input logic             reset,
    ps2_tx_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CW    = $clog2(4 * CLK_DIV);
    localparam logic [CW-1:0]      HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0]      BIT_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]      GUARD_LAST = CW'(4 * CLK_DIV - 1);
    localparam logic [FIFO_BITS:0] FULL_CNT   = (FIFO_BITS + 1)'(DEPTH);
    localparam logic               SRC_KBD    = 1'b0;
    localparam logic               SRC_MOUSE  = 1'b1;

    typedef enum logic [1:0] {IDLE, FRAME, GUARD} state_t;

    // Index 0 is the keyboard stream, index 1 the mouse stream.
    logic [1:0]           wr, full, push, pop, nonempty, ovf;
    logic [7:0]           din [2];
    logic [7:0]           mem [2][DEPTH];
    logic [FIFO_BITS-1:0] wp  [2];
    logic [FIFO_BITS-1:0] rp  [2];
    logic [FIFO_BITS:0]   cnt [2];

    state_t      state;
    logic [10:0] shreg;
    logic [3:0]  bit_idx;
    logic [CW-1:0] div_cnt;
    logic        sel;
    logic        last_grant;
    logic        busy_q;
    logic        kbd_clk_q, kbd_dat_q, mouse_clk_q, mouse_dat_q;
    logic        grant_valid;
    logic        grant_src;
    logic [7:0]  grant_byte;
    logic        bit_clk;
    logic        lock;

    assign wr     = {bus.mouse_wr, bus.kbd_wr};
    assign din[0] = bus.kbd_data;
    assign din[1] = bus.mouse_data;

    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < 2; i++) begin
            full[i]     = (cnt[i] == FULL_CNT);
            nonempty[i] = (cnt[i] != '0);
            push[i]     = wr[i] & ~full[i];
        end
    end

    // A write that meets a full FIFO is dropped even if a pop frees a slot on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i])  rp[i] <= rp[i] + 1'b1;
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
                if (wr[i] && full[i]) ovf[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wp[i]] <= din[i];
        end
    end

`ifdef PS2_MOUSE_PKT_LOCK_EN
    logic [1:0] pkt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            pkt_cnt <= 2'd0;
        end else if (grant_valid && grant_src == SRC_MOUSE) begin
            if (!lock) begin
                lock    <= 1'b1;
                pkt_cnt <= 2'd1;
            end else if (pkt_cnt == 2'd2) begin
                lock    <= 1'b0;
                pkt_cnt <= 2'd0;
            end else begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_KBD;
        pop         = '0;
        if (state == IDLE) begin
            if (lock) begin
                grant_valid = nonempty[1];
                grant_src   = SRC_MOUSE;
            end else if (&nonempty) begin
                grant_valid = 1'b1;
                grant_src   = ~last_grant;
            end else if (nonempty[0]) begin
                grant_valid = 1'b1;
                grant_src   = SRC_KBD;
            end else if (nonempty[1]) begin
                grant_valid = 1'b1;
                grant_src   = SRC_MOUSE;
            end
        end
        if (grant_valid) pop[grant_src] = 1'b1;
    end

    assign grant_byte = mem[grant_src][rp[grant_src]];
    assign bit_clk    = (div_cnt < HALF);

    // Bus outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '1;
            bit_idx     <= '0;
            div_cnt     <= '0;
            sel         <= SRC_KBD;
            last_grant  <= SRC_MOUSE;
            busy_q      <= 1'b0;
            kbd_clk_q   <= 1'b1;
            kbd_dat_q   <= 1'b1;
            mouse_clk_q <= 1'b1;
            mouse_dat_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    busy_q      <= 1'b0;
                    kbd_clk_q   <= 1'b1;
                    kbd_dat_q   <= 1'b1;
                    mouse_clk_q <= 1'b1;
                    mouse_dat_q <= 1'b1;
                    if (grant_valid) begin
                        shreg      <= {1'b1, ~^grant_byte, grant_byte, 1'b0};
                        sel        <= grant_src;
                        last_grant <= grant_src;
                        bit_idx    <= '0;
                        div_cnt    <= '0;
                        state      <= FRAME;
                    end
                end
                FRAME: begin
                    busy_q      <= 1'b1;
                    kbd_clk_q   <= (sel == SRC_KBD)   ? bit_clk  : 1'b1;
                    kbd_dat_q   <= (sel == SRC_KBD)   ? shreg[0] : 1'b1;
                    mouse_clk_q <= (sel == SRC_MOUSE) ? bit_clk  : 1'b1;
                    mouse_dat_q <= (sel == SRC_MOUSE) ? shreg[0] : 1'b1;
                    if (div_cnt == BIT_LAST) begin
                        div_cnt <= '0;
                        shreg   <= {1'b1, shreg[10:1]};
                        if (bit_idx == 4'd10) state <= GUARD;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    kbd_clk_q   <= 1'b1;
                    kbd_dat_q   <= 1'b1;
                    mouse_clk_q <= 1'b1;
                    mouse_dat_q <= 1'b1;
                    if (div_cnt == GUARD_LAST) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.kbd_full       = full[0];
    assign bus.mouse_full     = full[1];
    assign bus.kbd_ovf        = ovf[0];
    assign bus.mouse_ovf      = ovf[1];
    assign bus.busy           = busy_q;
    assign bus.ps2_kbd_clk    = kbd_clk_q;
    assign bus.ps2_kbd_data   = kbd_dat_q;
    assign bus.ps2_mouse_clk  = mouse_clk_q;
    assign bus.ps2_mouse_data = mouse_dat_q;
endmodule

// File: tb/tb_ps2_tx_arbiter.sv
// tb/tb_ps2_tx_arbiter.sv - scoreboard bench decoding both PS/2 buses against queued expected bytes
module tb_ps2_tx_arbiter;
    localparam int FB = 3;
    localparam int CD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ps2_tx_arbiter_if bus ();

    ps2_tx_arbiter #(.FIFO_BITS(FB), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         mouse;
        logic [7:0] data;
        bit         par;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic expect_byte(input bit m, input logic [7:0] d, input bit p);
        exp_t e;
        e.mouse = m;
        e.data  = d;
        e.par   = p;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_kbd(input logic [7:0] d);
        bus.kbd_data = d;
        bus.kbd_wr   = 1'b1;
        tick();
        bus.kbd_wr   = 1'b0;
    endtask

    task automatic wr_mouse(input logic [7:0] d);
        bus.mouse_data = d;
        bus.mouse_wr   = 1'b1;
        tick();
        bus.mouse_wr   = 1'b0;
    endtask

    task automatic wr_both(input logic [7:0] kd, input logic [7:0] md);
        bus.kbd_data   = kd;
        bus.mouse_data = md;
        bus.kbd_wr     = 1'b1;
        bus.mouse_wr   = 1'b1;
        tick();
        bus.kbd_wr     = 1'b0;
        bus.mouse_wr   = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (sb.size() == 0 && !bus.busy) break;
            tick();
        end
        check(name, {30'd0, sb.size() == 0, bus.busy}, 32'b10);
    endtask

    task automatic finish_frame(input bit m, input logic [10:0] fr, input bit dirty);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL frame_unexpected: got bus %0d frame %03h required no frame", m, fr);
        end else begin
            e = sb.pop_front();
            check("frame", {20'd0, m, fr}, {20'd0, e.mouse, 1'b1, e.par, e.data, 1'b0});
            check("other_bus_idle", {31'd0, dirty}, 32'd0);
        end
    endtask

    logic [10:0] kframe, mframe;
    int          kbits = 0, mbits = 0;
    logic        kprev = 1'b1, mprev = 1'b1;
    bit          kdirty = 0, mdirty = 0;

    always @(negedge clk) begin
        if (reset) begin
            kbits  = 0;
            mbits  = 0;
            kprev  = 1'b1;
            mprev  = 1'b1;
            kdirty = 0;
            mdirty = 0;
        end else begin
            if ((kbits > 0 || !bus.ps2_kbd_clk || !bus.ps2_kbd_data) &&
                !(bus.ps2_mouse_clk && bus.ps2_mouse_data)) kdirty = 1;
            if ((mbits > 0 || !bus.ps2_mouse_clk || !bus.ps2_mouse_data) &&
                !(bus.ps2_kbd_clk && bus.ps2_kbd_data)) mdirty = 1;
            if (kprev && !bus.ps2_kbd_clk) begin
                kframe[kbits] = bus.ps2_kbd_data;
                kbits++;
                if (kbits == 11) begin
                    finish_frame(1'b0, kframe, kdirty);
                    kbits  = 0;
                    kdirty = 0;
                end
            end
            if (mprev && !bus.ps2_mouse_clk) begin
                mframe[mbits] = bus.ps2_mouse_data;
                mbits++;
                if (mbits == 11) begin
                    finish_frame(1'b1, mframe, mdirty);
                    mbits  = 0;
                    mdirty = 0;
                end
            end
            kprev = bus.ps2_kbd_clk;
            mprev = bus.ps2_mouse_clk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bcnt;
        bit   act;
        logic par_tab [8];
        par_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        bus.kbd_data   = 8'h00;
        bus.kbd_wr     = 1'b0;
        bus.mouse_data = 8'h00;
        bus.mouse_wr   = 1'b0;
        repeat (3) tick();
        check("reset_ps2", {bus.ps2_kbd_clk, bus.ps2_kbd_data, bus.ps2_mouse_clk, bus.ps2_mouse_data}, 4'hF);
        check("reset_busy", bus.busy, 0);
        check("reset_flags", {bus.kbd_full, bus.mouse_full, bus.kbd_ovf, bus.mouse_ovf}, 4'h0);
        reset = 1'b0;
        tick();

        // Single byte, latency and busy length
        expect_byte(0, 8'h1C, 0);
        wr_kbd(8'h1C);
        check("lat_edge_n", bus.ps2_kbd_data, 1);
        tick();
        check("lat_edge_n1", {bus.ps2_kbd_data, bus.busy}, 2'b10);
        tick();
        check("start_bit", {bus.ps2_kbd_clk, bus.ps2_kbd_data}, 2'b10);
        check("busy_start", bus.busy, 1);
        bcnt = 0;
        for (int i = 0; i < 1000 && bus.busy; i++) begin
            bcnt++;
            tick();
        end
        check("busy_len", bcnt, 26 * CD - 1);
        drain("drain_single");

        // Parity corners
        expect_byte(0, 8'h00, 1);
        expect_byte(0, 8'hFF, 1);
        expect_byte(0, 8'h01, 0);
        wr_kbd(8'h00);
        wr_kbd(8'hFF);
        wr_kbd(8'h01);
        drain("drain_parity");

        // Overflow: one byte in flight, then 9 writes into an 8-deep FIFO
        expect_byte(0, 8'h55, 1);
        wr_kbd(8'h55);
        tick();
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_byte(0, 8'h10 + 8'(i), par_tab[i]);
            wr_kbd(8'h10 + 8'(i));
            if (i == 6) check("full_after_7", bus.kbd_full, 0);
            if (i == 7) check("full_ovf_after_8", {bus.kbd_full, bus.kbd_ovf}, 2'b10);
            if (i == 8) check("full_ovf_after_9", {bus.kbd_full, bus.kbd_ovf}, 2'b11);
        end
        drain("drain_overflow");
        check("ovf_sticky", {bus.kbd_ovf, bus.kbd_full, bus.mouse_ovf}, 3'b100);

        // Mouse packet vs keyboard (last grant was keyboard, so mouse goes first)
        expect_byte(1, 8'h08, 0);
`ifdef PS2_MOUSE_PKT_LOCK_EN
        expect_byte(1, 8'h01, 0);
        expect_byte(1, 8'hFF, 1);
        expect_byte(0, 8'h1C, 0);
`else
        expect_byte(0, 8'h1C, 0);
        expect_byte(1, 8'h01, 0);
        expect_byte(1, 8'hFF, 1);
`endif
        wr_both(8'h1C, 8'h08);
        wr_mouse(8'h01);
        wr_mouse(8'hFF);
        drain("drain_lock");

        // Reset in the middle of bit 4 with more bytes queued
        wr_kbd(8'h5A);
        wr_kbd(8'h33);
        wr_mouse(8'h44);
        repeat (34) tick();
        check("busy_before_reset", {bus.busy, bus.ps2_kbd_clk}, 2'b11);
        reset = 1'b1;
        #1;
        check("rst_async_ps2", {bus.ps2_kbd_clk, bus.ps2_kbd_data, bus.ps2_mouse_clk, bus.ps2_mouse_data}, 4'hF);
        check("rst_async_flags", {bus.busy, bus.kbd_full, bus.mouse_full, bus.kbd_ovf, bus.mouse_ovf}, 5'h0);
        tick();
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.busy || !(bus.ps2_kbd_clk && bus.ps2_kbd_data && bus.ps2_mouse_clk && bus.ps2_mouse_data))
                act = 1;
        end
        check("no_frame_after_reset", act, 0);

        // Round-robin after reset: keyboard first
        expect_byte(0, 8'hA1, 0);
        expect_byte(1, 8'hB1, 1);
`ifdef PS2_MOUSE_PKT_LOCK_EN
        expect_byte(1, 8'hB2, 1);
        expect_byte(1, 8'hB3, 0);
        expect_byte(0, 8'hA2, 0);
`else
        expect_byte(0, 8'hA2, 0);
        expect_byte(1, 8'hB2, 1);
        expect_byte(1, 8'hB3, 0);
`endif
        wr_both(8'hA1, 8'hB1);
        wr_both(8'hA2, 8'hB2);
        wr_mouse(8'hB3);
        drain("drain_round_robin");
        repeat (20) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
